// File: rtl/instr_fetch_pkg.sv
// Shared constants and the fetch state type for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_pkg;

    localparam int INSTR_BYTES      = 4;
    localparam int WORD_BYTES       = 2;
    localparam int ADDR_BITS        = 16;
    localparam int WORD_BITS        = 16;
    localparam int FETCH_LINE_BYTES = 16;

    typedef enum logic [1:0] {
        PRE_BOOT = 2'd0,
        READY    = 2'd1,
        REQ      = 2'd2,
        WAIT     = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_line_buf.sv
// Single-line word store for the fetch stage: one word write port, one 32-bit instruction read port.
// Latency: write lands on the next clk edge; read is combinational (zero cycles).
// Backpressure: none; the writer owns all sequencing.
//
// Ports:
//   clk      - clock
//   we_i     - write enable for word widx_i
//   widx_i   - word index within the line
//   wdata_i  - word to store
//   iidx_i   - instruction index within the line
//   instr_o  - {word[2*iidx], word[2*iidx+1]}, lower address in the upper half
module fetch_line_buf #(
    parameter int WORD_BITS  = 16,
    parameter int LINE_BYTES = 16
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [$clog2(LINE_BYTES)-2:0] widx_i,
    input  logic [WORD_BITS-1:0]          wdata_i,
    input  logic [$clog2(LINE_BYTES)-3:0] iidx_i,
    output logic [2*WORD_BITS-1:0]        instr_o
);
    import instr_fetch_pkg::*;

    localparam int NWORDS = LINE_BYTES / WORD_BYTES;

    // Contents are meaningless until a complete fill has landed; the owner
    // qualifies every read with its own valid flag, so no reset is needed.
    logic [WORD_BITS-1:0] words_q [NWORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            words_q[widx_i] <= wdata_i;
        end
    end

    assign instr_o = {words_q[{iidx_i, 1'b0}], words_q[{iidx_i, 1'b1}]};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: turns a byte pointer into a 32-bit instruction via a one-line prefetch buffer.
// Latency: hits are combinational (0 cycles); a miss costs 1 + 2*(LINE_BYTES/2) cycles with 1-cycle memory.
// Backpressure: one memory read outstanding at a time; the next word is requested only after mem_rd_done.
//
// Ports:
//   clk, rst_n                - clock, synchronous active-low reset
//   boot_done                 - memory image loaded; fetching starts only after this is seen
//   instr_ptr                 - byte address of the wanted instruction (bits [1:0] ignored)
//   instr_valid, cur_instr    - hit indication and instruction ({A, A+2} halves)
//   snoop_wr_en/_addr         - processor data writes, used to invalidate stale code
//   mem_rd_en/_addr/_data/_done - word-wide memory read handshake
module instr_fetch #(
    parameter int ADDR_BITS  = instr_fetch_pkg::ADDR_BITS,
    parameter int WORD_BITS  = instr_fetch_pkg::WORD_BITS,
    parameter int LINE_BYTES = instr_fetch_pkg::FETCH_LINE_BYTES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 boot_done,
    input  logic [ADDR_BITS-1:0] instr_ptr,
    output logic                 instr_valid,
    output logic [31:0]          cur_instr,
    input  logic                 snoop_wr_en,
    input  logic [ADDR_BITS-1:0] snoop_wr_addr,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_rd_addr,
    input  logic [WORD_BITS-1:0] mem_rd_data,
    input  logic                 mem_rd_done
);
    import instr_fetch_pkg::*;

    localparam int OFF_BITS  = $clog2(LINE_BYTES);
    localparam int TAG_BITS  = ADDR_BITS - OFF_BITS;
    localparam int WIDX_BITS = OFF_BITS - 1;
    localparam int IIDX_BITS = OFF_BITS - 2;
    localparam logic [WIDX_BITS-1:0] LAST_WORD = WIDX_BITS'(LINE_BYTES / WORD_BYTES - 1);

    fetch_state_t         state_q, state_d;
    logic                 line_valid_q, line_valid_d;
    logic [TAG_BITS-1:0]  line_tag_q, line_tag_d;
    logic [TAG_BITS-1:0]  fill_tag_q, fill_tag_d;
    logic [WIDX_BITS-1:0] word_idx_q, word_idx_d;
    logic                 fill_dirty_q, fill_dirty_d;

    logic [TAG_BITS-1:0]  ptr_tag;
    logic [IIDX_BITS-1:0] ptr_idx;
    logic [TAG_BITS-1:0]  snoop_tag;
    logic                 line_hit;
    logic                 snoop_line_hit;
    logic                 snoop_fill_hit;
    logic                 buf_we;
    logic                 unused_addr_bits;

    assign ptr_tag   = instr_ptr[ADDR_BITS-1:OFF_BITS];
    assign ptr_idx   = instr_ptr[OFF_BITS-1:2];
    assign snoop_tag = snoop_wr_addr[ADDR_BITS-1:OFF_BITS];

    // Byte offsets below instruction / line granularity carry no information here.
    assign unused_addr_bits = ^{instr_ptr[1:0], snoop_wr_addr[OFF_BITS-1:0]};

    assign line_hit       = line_valid_q && (ptr_tag == line_tag_q);
    assign snoop_line_hit = snoop_wr_en && (snoop_tag == line_tag_q);
    assign snoop_fill_hit = snoop_wr_en && ((state_q == REQ) || (state_q == WAIT))
                            && (snoop_tag == fill_tag_q);
    assign buf_we         = (state_q == WAIT) && mem_rd_done;

    assign instr_valid = line_hit && (state_q == READY);
    assign mem_rd_en   = (state_q == REQ);
    // fill_tag/word_idx only move on a miss or on mem_rd_done, so the address
    // is naturally held for the whole request/wait window.
    assign mem_rd_addr = {fill_tag_q, word_idx_q, 1'b0};

    fetch_line_buf #(
        .WORD_BITS  (WORD_BITS),
        .LINE_BYTES (LINE_BYTES)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .widx_i  (word_idx_q),
        .wdata_i (mem_rd_data),
        .iidx_i  (ptr_idx),
        .instr_o (cur_instr)
    );

    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        fill_tag_d   = fill_tag_q;
        word_idx_d   = word_idx_q;
        fill_dirty_d = fill_dirty_q;

        if (snoop_line_hit) begin
            line_valid_d = 1'b0;
        end
        if (snoop_fill_hit) begin
            fill_dirty_d = 1'b1;
        end

        unique case (state_q)
            PRE_BOOT: begin
                if (boot_done) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (!line_hit) begin
                    fill_tag_d   = ptr_tag;
                    word_idx_d   = '0;
                    fill_dirty_d = 1'b0;
                    line_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_rd_done) begin
                    if (word_idx_q == LAST_WORD) begin
                        // A write to this line in the landing cycle still poisons it.
                        line_tag_d   = fill_tag_q;
                        line_valid_d = !(fill_dirty_q || snoop_fill_hit);
                        state_d      = READY;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            default: begin
                state_d = PRE_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= PRE_BOOT;
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            fill_tag_q   <= '0;
            word_idx_q   <= '0;
            fill_dirty_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            line_tag_q   <= line_tag_d;
            fill_tag_q   <= fill_tag_d;
            word_idx_q   <= word_idx_d;
            fill_dirty_q <= fill_dirty_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a line-level model.
// Latency: n/a.
// Backpressure: memory responder answers one read at a time with 1..3 cycle latency.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        boot_done;
    logic [15:0] instr_ptr;
    logic        instr_valid;
    logic [31:0] cur_instr;
    logic        snoop_wr_en;
    logic [15:0] snoop_wr_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        mem_rd_done;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .boot_done     (boot_done),
        .instr_ptr     (instr_ptr),
        .instr_valid   (instr_valid),
        .cur_instr     (cur_instr),
        .snoop_wr_en   (snoop_wr_en),
        .snoop_wr_addr (snoop_wr_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_done   (mem_rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    logic [15:0] mem [32768];
    logic [15:0] rd_log [$];
    int          lat      = 1;
    bit          lat_rand = 1'b0;

    // Line-level reference: what the line holds, whether it is usable,
    // and how far an in-progress fill has got.
    bit          m_boot  = 1'b0;
    bit          m_fill  = 1'b0;
    bit          m_out   = 1'b0;
    bit          m_ok    = 1'b0;
    bit          m_dirty = 1'b0;
    logic [11:0] m_ltag  = '0;
    logic [11:0] m_ftag  = '0;
    int          m_got   = 0;
    logic [15:0] m_line [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: compare this cycle's outputs, then advance by one cycle.
    task automatic model_step();
        logic [11:0] ptag;
        int          ii;
        bit          hit;
        bit          e_valid;
        bit          e_en;
        logic [15:0] ea;
        ptag    = instr_ptr[15:4];
        ii      = int'(instr_ptr[3:2]);
        hit     = m_ok && (ptag == m_ltag);
        e_valid = m_boot && !m_fill && hit;
        e_en    = m_fill && !m_out;
        if (chk_on) begin
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
            if (e_valid) chk("cur_instr", cur_instr, {m_line[2*ii], m_line[2*ii+1]});
            chk("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, e_en});
            if (e_en) begin
                ea = {m_ftag, 4'h0} | 16'(m_got * 2);
                chk("mem_rd_addr", {16'b0, mem_rd_addr}, {16'b0, ea});
            end
        end
        if (!rst_n) begin
            m_boot = 0; m_fill = 0; m_out = 0; m_ok = 0; m_dirty = 0; m_got = 0;
        end else begin
            if (snoop_wr_en && snoop_wr_addr[15:4] == m_ltag) m_ok = 0;
            if (snoop_wr_en && m_fill && snoop_wr_addr[15:4] == m_ftag) m_dirty = 1;
            if (!m_boot) begin
                m_boot = boot_done;
            end else if (!m_fill) begin
                if (!hit) begin
                    m_fill = 1; m_ftag = ptag; m_got = 0; m_dirty = 0; m_ok = 0; m_out = 0;
                end
            end else if (!m_out) begin
                m_out = 1;
            end else if (mem_rd_done) begin
                m_line[m_got] = mem_rd_data;
                m_got++;
                m_out = 0;
                if (m_got == 8) begin
                    m_fill = 0;
                    m_ltag = m_ftag;
                    m_ok   = !m_dirty;
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // Memory: accepts a request seen on a negedge, answers lat cycles later.
    initial begin
        bit          pend;
        int          pcnt;
        logic [15:0] paddr;
        pend = 0; pcnt = 0; paddr = '0;
        mem_rd_done = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_en === 1'b1 && !pend) begin
                pend  = 1;
                paddr = mem_rd_addr;
                pcnt  = lat_rand ? int'($urandom_range(1, 3)) : lat;
                rd_log.push_back(mem_rd_addr);
            end
            @(posedge clk);
            #1;
            mem_rd_done = 1'b0;
            if (pend) begin
                pcnt--;
                if (pcnt == 0) begin
                    mem_rd_done = 1'b1;
                    mem_rd_data = mem[paddr[15:1]];
                    pend        = 0;
                end
            end
        end
    end

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk);
            if (instr_valid === 1'b1) return;
            n++;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_valid: instr_valid not seen within %0d cycles", max);
    endtask

    task automatic wait_en(input logic [15:0] addr, input int max);
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (mem_rd_en === 1'b1 && mem_rd_addr === addr) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_en: read of %h not seen within %0d cycles", addr, max);
    endtask

    task automatic chk_reads(input logic [15:0] base, input int nfills);
        chk("read_count", rd_log.size(), 8 * nfills);
        for (int i = 0; i < rd_log.size() && i < 8 * nfills; i++) begin
            chk("read_addr", {16'b0, rd_log[i]}, {16'b0, base | 16'((i % 8) * 2)});
        end
        rd_log.delete();
    endtask

    logic [15:0] hit_ptr [4] = '{16'h0004, 16'h0008, 16'h000C, 16'h0005};
    logic [31:0] hit_exp [4] = '{32'h00040006, 32'h0008000A, 32'h000C000E, 32'h00040006};

    initial begin
        int          n;
        int          hold;
        logic [15:0] b;
        rst_n = 1'b0; boot_done = 1'b0; instr_ptr = '0;
        snoop_wr_en = 1'b0; snoop_wr_addr = '0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 2);

        // Reset state
        tick(); tick();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_mem_rd_en",   {31'b0, mem_rd_en},   32'd0);
        chk("rst_mem_rd_addr", {16'b0, mem_rd_addr}, 32'd0);

        // Cold boot: boot_done raised at cycle 5, line 0 fetched
        tick(); rst_n = 1'b1;
        tick(); tick();
        boot_done = 1'b1;
        wait_valid(100, n);
        chk("boot_to_valid_cycles", n, 32'd18);
        chk("cold_cur_instr", cur_instr, 32'h00000002);
        chk_reads(16'h0000, 1);

        // Sequential hits within the line, including a misaligned pointer
        for (int i = 0; i < 4; i++) begin
            tick(); instr_ptr = hit_ptr[i];
            @(negedge clk);
            chk("seq_hit_valid", {31'b0, instr_valid}, 32'd1);
            chk("seq_hit_instr", cur_instr, hit_exp[i]);
        end
        chk("seq_hit_no_reads", rd_log.size(), 32'd0);

        // Line crossing
        tick(); instr_ptr = 16'h0010;
        @(negedge clk);
        chk("cross_valid_drop", {31'b0, instr_valid}, 32'd0);
        wait_valid(100, n);
        chk("cross_cur_instr", cur_instr, 32'h00100012);
        chk_reads(16'h0010, 1);

        // Top-of-memory line
        tick(); instr_ptr = 16'hFFFC;
        wait_valid(100, n);
        chk("wrap_cur_instr", cur_instr, 32'hFFFCFFFE);
        chk_reads(16'hFFF0, 1);

        // Snoop: unrelated line leaves the hit alone, same line forces refetch
        tick(); instr_ptr = 16'h0000;
        wait_valid(100, n);
        rd_log.delete();
        tick(); snoop_wr_en = 1'b1; snoop_wr_addr = 16'h0020;
        tick(); snoop_wr_en = 1'b0;
        @(negedge clk);
        chk("snoop_other_valid", {31'b0, instr_valid}, 32'd1);
        tick(); snoop_wr_en = 1'b1; snoop_wr_addr = 16'h0006;
        tick(); snoop_wr_en = 1'b0;
        @(negedge clk);
        chk("snoop_hit_valid", {31'b0, instr_valid}, 32'd0);
        wait_valid(100, n);
        chk_reads(16'h0000, 1);

        // Snoop into the line being filled: two complete fills before a hit
        tick(); instr_ptr = 16'h0040;
        wait_en(16'h004A, 100);
        tick(); snoop_wr_en = 1'b1; snoop_wr_addr = 16'h0044;
        tick(); snoop_wr_en = 1'b0;
        wait_valid(200, n);
        chk("dirty_fill_instr", cur_instr, 32'h00400042);
        chk_reads(16'h0040, 2);

        // Reset during WAIT at word 3; the late done must be ignored
        tick(); lat = 3; instr_ptr = 16'h0080;
        wait_en(16'h0086, 100);
        tick(); rst_n = 1'b0; boot_done = 1'b0;
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("midrst_mem_rd_en",   {31'b0, mem_rd_en},   32'd0);
        chk("midrst_mem_rd_addr", {16'b0, mem_rd_addr}, 32'd0);
        repeat (5) tick();
        rd_log.delete();
        lat = 1; boot_done = 1'b1;
        wait_valid(100, n);
        chk("midrst_cur_instr", cur_instr, 32'h00800082);
        chk_reads(16'h0080, 1);

        // Randomized traffic checked cycle by cycle by the model
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        lat_rand = 1'b1;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst_n = 1'b1;
            if (hold > 0) begin
                hold--;
                if (hold == 0) boot_done = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       b = 16'h0000;
                    1:       b = 16'h0010;
                    2:       b = 16'h0020;
                    default: b = 16'hFFF0;
                endcase
                instr_ptr = b | 16'($urandom_range(0, 15));
            end
            snoop_wr_en = ($urandom_range(0, 15) == 0);
            if (snoop_wr_en) begin
                case ($urandom_range(0, 3))
                    0:       b = 16'h0000;
                    1:       b = 16'h0010;
                    2:       b = 16'h0030;
                    default: b = 16'hFFF0;
                endcase
                snoop_wr_addr = b | 16'($urandom_range(0, 15));
                mem[snoop_wr_addr[15:1]] = 16'($urandom);
            end
            if (hold == 0 && $urandom_range(0, 599) == 0) begin
                rst_n = 1'b0; boot_done = 1'b0; hold = 6;
            end
        end
        tick();
        snoop_wr_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
